// File: rtl/wino_btdb_stream.sv
// Streaming Winograd F(2,3) input transform (BT*D*B), one tile row per beat.
// Two-stage tile buffer: the load stage collects rows, and the drain stage emits the transformed rows.
module wino_btdb_stream #(
  parameter int DATA_WIDTH = 18,
  parameter int OUT_WIDTH  = DATA_WIDTH + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [4*DATA_WIDTH-1:0] in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*OUT_WIDTH-1:0] out_row,
  output logic                   out_last,
  output logic                   out_mode
);

  localparam int DW = DATA_WIDTH;
  localparam int OW = OUT_WIDTH;

  logic signed [OW-1:0] load_buf_reg  [4][4];
  logic signed [OW-1:0] drain_buf_reg [4][4];
  logic [1:0]           load_cnt_reg;
  logic                 load_mode_reg;
  logic                 load_full_reg;
  logic                 ready_en_reg;
  logic [1:0]           drain_cnt_reg;
  logic                 drain_mode_reg;
  logic                 drain_valid_reg;

  logic signed [OW-1:0] in_ext [4];
  logic signed [OW-1:0] src    [4][4];
  logic signed [OW-1:0] row_t  [4][4];
  logic signed [OW-1:0] col_t  [4][4];

  logic       accept;
  logic       tile_done;
  logic       drain_last;
  logic       drain_free;
  logic       xfer;
  logic       load_mode_eff;
  logic [1:0] load_last_idx;

  assign drain_last    = drain_cnt_reg == (drain_mode_reg ? 2'd2 : 2'd3);
  assign drain_free    = !drain_valid_reg || (out_ready && drain_last);
  assign in_ready      = ready_en_reg && (!load_full_reg || drain_free);
  assign accept        = in_valid && in_ready;
  assign load_mode_eff = (load_cnt_reg == 2'd0) ? in_mode : load_mode_reg;
  assign load_last_idx = load_mode_eff ? 2'd2 : 2'd3;
  assign tile_done     = accept && !load_full_reg && (load_cnt_reg == load_last_idx);
  assign xfer          = (load_full_reg || tile_done) && drain_free;

  // A tile whose last row arrives this cycle bypasses straight into the transform,
  // so a drain that is just emptying never sees a bubble.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign in_ext[gi] = {{(OW-DW){in_row[gi*DW+DW-1]}}, in_row[gi*DW +: DW]};
      for (gj = 0; gj < 4; gj++) begin : g_src
        assign src[gj][gi] = (accept && !load_full_reg && load_cnt_reg == 2'(gj)) ?
                             in_ext[gi] : load_buf_reg[gj][gi];
      end
      assign row_t[0][gi] = load_mode_reg ? src[0][gi] + src[1][gi] : src[0][gi] - src[2][gi];
      assign row_t[1][gi] = load_mode_reg ? src[1][gi] - src[0][gi] : src[1][gi] + src[2][gi];
      assign row_t[2][gi] = load_mode_reg ? src[2][gi] - src[0][gi] : src[2][gi] - src[1][gi];
      assign row_t[3][gi] = src[1][gi] - src[3][gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign col_t[gi][0] = row_t[gi][0] - row_t[gi][2];
      assign col_t[gi][1] = row_t[gi][1] + row_t[gi][2];
      assign col_t[gi][2] = row_t[gi][2] - row_t[gi][1];
      assign col_t[gi][3] = row_t[gi][1] - row_t[gi][3];
      assign out_row[gi*OW +: OW] = drain_valid_reg ? drain_buf_reg[drain_cnt_reg][gi] : '0;
    end
  endgenerate

  assign out_valid = drain_valid_reg;
  assign out_last  = drain_valid_reg && drain_last;
  assign out_mode  = drain_mode_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < 4; j++) load_buf_reg[load_cnt_reg][j] <= in_ext[j];
    end
    if (xfer) drain_buf_reg <= col_t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en_reg    <= 1'b0;
      load_cnt_reg    <= 2'd0;
      load_mode_reg   <= 1'b0;
      load_full_reg   <= 1'b0;
      drain_cnt_reg   <= 2'd0;
      drain_mode_reg  <= 1'b0;
      drain_valid_reg <= 1'b0;
    end else begin
      ready_en_reg  <= 1'b1;
      load_full_reg <= (load_full_reg || tile_done) && !xfer;
      if (accept) begin
        if (load_cnt_reg == 2'd0) load_mode_reg <= in_mode;
        load_cnt_reg <= (load_cnt_reg == load_last_idx) ? 2'd0 : load_cnt_reg + 2'd1;
      end
      if (xfer) begin
        drain_mode_reg  <= load_mode_reg;
        drain_cnt_reg   <= 2'd0;
        drain_valid_reg <= 1'b1;
      end else if (drain_valid_reg && out_ready) begin
        if (drain_last) begin
          drain_valid_reg <= 1'b0;
          drain_cnt_reg   <= 2'd0;
        end else begin
          drain_cnt_reg <= drain_cnt_reg + 2'd1;
        end
      end
    end
  end

endmodule
